// File: rtl/lane_wb_pkg.sv
// Shared types and helpers for the lane write-back stage.
// Entry widths here describe the default configuration; the top re-derives them from its parameters.
package lane_wb_pkg;

    localparam int unsigned WB_DATA_WIDTH   = 32;
    localparam int unsigned WB_VD_WIDTH     = 5;
    localparam int unsigned WB_OFFSET_WIDTH = 1;
    localparam int unsigned WB_INST_WIDTH   = 3;

    function automatic int unsigned mask_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    localparam int unsigned WB_MASK_W = mask_width(WB_DATA_WIDTH);

    typedef struct packed {
        logic [WB_VD_WIDTH-1:0]     vd;
        logic [WB_OFFSET_WIDTH-1:0] offset;
        logic [WB_MASK_W-1:0]       mask;
        logic [WB_DATA_WIDTH-1:0]   data;
        logic                       last;
        logic [WB_INST_WIDTH-1:0]   instruction_index;
    } wb_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/lane_wb_fifo.sv
// Generic synchronous FIFO of write-back entries; a push is legal when full if a pop
// happens in the same cycle.
module lane_wb_fifo
    import lane_wb_pkg::*;
#(
    parameter type         entry_t = wb_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  entry_t                     wdata_i,
    input  logic                       pop_i,
    output entry_t                     rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/lane_stage3_wb.sv
// Lane write-back stage: computes VRF addresses, splits cross writes into two entries,
// buffers them and tracks outstanding writes per instruction tag.
module lane_stage3_wb
    import lane_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned QUEUE_DEPTH  = 4,
    parameter int unsigned GC_WIDTH     = 5,
    parameter int unsigned OFFSET_WIDTH = 1,
    parameter int unsigned VD_WIDTH     = 5,
    parameter int unsigned INST_WIDTH   = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          enq_ready,
    input  logic                          enq_valid,
    input  logic [GC_WIDTH-1:0]           enq_group_counter,
    input  logic [DATA_WIDTH-1:0]         enq_data,
    input  logic [DATA_WIDTH/8-1:0]       enq_mask,
    input  logic                          enq_cross_write,
    input  logic [2*DATA_WIDTH-1:0]       enq_cross_data,
    input  logic [2*(DATA_WIDTH/8)-1:0]   enq_cross_mask,
    input  logic                          enq_last,
    input  logic [VD_WIDTH-1:0]           enq_vd,
    input  logic [INST_WIDTH-1:0]         enq_instruction_index,
    input  logic                          vrf_ready,
    output logic                          vrf_valid,
    output logic [VD_WIDTH-1:0]           vrf_vd,
    output logic [OFFSET_WIDTH-1:0]       vrf_offset,
    output logic [DATA_WIDTH/8-1:0]       vrf_mask,
    output logic [DATA_WIDTH-1:0]         vrf_data,
    output logic                          vrf_last,
    output logic [INST_WIDTH-1:0]         vrf_instruction_index,
    output logic [(2**INST_WIDTH)-1:0]    inst_pending,
    output logic                          queue_empty
);

    localparam int unsigned MASK_W   = mask_width(DATA_WIDTH);
    localparam int unsigned NUM_TAGS = 2 ** INST_WIDTH;
    localparam int unsigned CW       = $clog2(QUEUE_DEPTH + 2);
    localparam int unsigned AW       = (VD_WIDTH > GC_WIDTH + 1) ? VD_WIDTH : GC_WIDTH + 1;

    typedef struct packed {
        logic [VD_WIDTH-1:0]     vd;
        logic [OFFSET_WIDTH-1:0] offset;
        logic [MASK_W-1:0]       mask;
        logic [DATA_WIDTH-1:0]   data;
        logic                    last;
        logic [INST_WIDTH-1:0]   instruction_index;
    } entry_t;

    function automatic entry_t make_entry(input logic [VD_WIDTH-1:0]     vd,
                                          input logic [GC_WIDTH:0]       egc,
                                          input logic [MASK_W-1:0]       mask,
                                          input logic [DATA_WIDTH-1:0]   data,
                                          input logic                    last,
                                          input logic [INST_WIDTH-1:0]   tag);
        logic [AW-1:0] sum;
        entry_t        e;
        sum = AW'(vd) + AW'(egc >> OFFSET_WIDTH);
        e.vd                = sum[VD_WIDTH-1:0];
        e.offset            = egc[OFFSET_WIDTH-1:0];
        e.mask              = mask;
        e.data              = data;
        e.last              = last;
        e.instruction_index = tag;
        return e;
    endfunction

    // A zero-mask entry is only worth a VRF write when it carries the last flag.
    function automatic logic keep_entry(input entry_t e);
        return (e.mask != '0) || e.last;
    endfunction

    wb_state_e          state_q, state_d;
    entry_t             hold_q, hold_d;
    logic               hold_keep_q, hold_keep_d;
    logic [CW-1:0]      cnt_q [NUM_TAGS];
    logic [CW-1:0]      cnt_d [NUM_TAGS];

    entry_t             entry_n, entry_c0, entry_c1, push_entry, head;
    logic               push, idle_push, latch_inc, can_push;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(QUEUE_DEPTH+1)-1:0] fifo_count;

    always_comb begin
        entry_n  = make_entry(enq_vd, {1'b0, enq_group_counter}, enq_mask, enq_data,
                              enq_last, enq_instruction_index);
        entry_c0 = make_entry(enq_vd, {enq_group_counter, 1'b0}, enq_cross_mask[MASK_W-1:0],
                              enq_cross_data[DATA_WIDTH-1:0], 1'b0, enq_instruction_index);
        entry_c1 = make_entry(enq_vd, {enq_group_counter, 1'b1},
                              enq_cross_mask[2*MASK_W-1:MASK_W],
                              enq_cross_data[2*DATA_WIDTH-1:DATA_WIDTH], enq_last,
                              enq_instruction_index);
    end

    assign fifo_pop = ~fifo_empty & vrf_ready;
    // A pop in the same cycle frees the slot, so a full queue can still take a push.
    assign can_push = ~fifo_full | fifo_pop;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_keep_d = hold_keep_q;
        push        = 1'b0;
        push_entry  = entry_n;
        enq_ready   = 1'b0;
        latch_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                enq_ready = can_push;
                if (enq_valid && can_push) begin
                    if (enq_cross_write) begin
                        push_entry  = entry_c0;
                        push        = keep_entry(entry_c0);
                        hold_d      = entry_c1;
                        hold_keep_d = keep_entry(entry_c1);
                        latch_inc   = keep_entry(entry_c1);
                        state_d     = SPLIT;
                    end else begin
                        push = keep_entry(entry_n);
                    end
                end
            end
            SPLIT: begin
                push_entry = hold_q;
                if (!hold_keep_q) begin
                    state_d = IDLE;
                end else if (can_push) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held half 1 was already counted when latched; moving it into the FIFO is count-neutral.
    assign idle_push = push & (state_q == IDLE);

    always_comb begin
        inst_pending = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            cnt_d[t] = cnt_q[t]
                     + CW'(idle_push && (enq_instruction_index == INST_WIDTH'(t)))
                     + CW'(latch_inc && (enq_instruction_index == INST_WIDTH'(t)))
                     - CW'(fifo_pop && (head.instruction_index == INST_WIDTH'(t)));
            inst_pending[t] = (cnt_q[t] != '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_keep_q <= 1'b0;
            for (int t = 0; t < NUM_TAGS; t++) begin
                cnt_q[t] <= '0;
            end
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_keep_q <= hold_keep_d;
            for (int t = 0; t < NUM_TAGS; t++) begin
                cnt_q[t] <= cnt_d[t];
            end
        end
    end

    lane_wb_fifo #(
        .entry_t (entry_t),
        .DEPTH   (QUEUE_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign vrf_valid             = ~fifo_empty;
    assign vrf_vd                = head.vd;
    assign vrf_offset            = head.offset;
    assign vrf_mask              = head.mask;
    assign vrf_data              = head.data;
    assign vrf_last              = head.last;
    assign vrf_instruction_index = head.instruction_index;
    assign queue_empty           = (fifo_count == '0);

endmodule

// File: tb/tb_lane_stage3_wb.sv
// Directed bench for the lane write-back stage with hand-computed expectations.
module tb_lane_stage3_wb;

    logic        clock;
    logic        reset;
    logic        enq_ready;
    logic        enq_valid;
    logic [4:0]  enq_group_counter;
    logic [31:0] enq_data;
    logic [3:0]  enq_mask;
    logic        enq_cross_write;
    logic [63:0] enq_cross_data;
    logic [7:0]  enq_cross_mask;
    logic        enq_last;
    logic [4:0]  enq_vd;
    logic [2:0]  enq_instruction_index;
    logic        vrf_ready;
    logic        vrf_valid;
    logic [4:0]  vrf_vd;
    logic [0:0]  vrf_offset;
    logic [3:0]  vrf_mask;
    logic [31:0] vrf_data;
    logic        vrf_last;
    logic [2:0]  vrf_instruction_index;
    logic [7:0]  inst_pending;
    logic        queue_empty;

    int nchecks = 0;
    int nerrors = 0;

    lane_stage3_wb u_dut (
        .clock                 (clock),
        .reset                 (reset),
        .enq_ready             (enq_ready),
        .enq_valid             (enq_valid),
        .enq_group_counter     (enq_group_counter),
        .enq_data              (enq_data),
        .enq_mask              (enq_mask),
        .enq_cross_write       (enq_cross_write),
        .enq_cross_data        (enq_cross_data),
        .enq_cross_mask        (enq_cross_mask),
        .enq_last              (enq_last),
        .enq_vd                (enq_vd),
        .enq_instruction_index (enq_instruction_index),
        .vrf_ready             (vrf_ready),
        .vrf_valid             (vrf_valid),
        .vrf_vd                (vrf_vd),
        .vrf_offset            (vrf_offset),
        .vrf_mask              (vrf_mask),
        .vrf_data              (vrf_data),
        .vrf_last              (vrf_last),
        .vrf_instruction_index (vrf_instruction_index),
        .inst_pending          (inst_pending),
        .queue_empty           (queue_empty)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid             = 1'b0;
        enq_group_counter     = '0;
        enq_data              = '0;
        enq_mask              = '0;
        enq_cross_write       = 1'b0;
        enq_cross_data        = '0;
        enq_cross_mask        = '0;
        enq_last              = 1'b0;
        enq_vd                = '0;
        enq_instruction_index = '0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        vrf_ready = 1'b0;
        idle_inputs();
        #2;
        nchecks++; if (vrf_valid !== 1'b0) begin nerrors++; $display("FAIL reset_vrf_valid: got %b expected 0", vrf_valid); end
        nchecks++; if (inst_pending !== 8'h00) begin nerrors++; $display("FAIL reset_pending: got %h expected 00", inst_pending); end
        nchecks++; if (queue_empty !== 1'b1) begin nerrors++; $display("FAIL reset_queue_empty: got %b expected 1", queue_empty); end
        nchecks++; if (enq_ready !== 1'b1) begin nerrors++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        vrf_ready             = 1'b0;
        enq_valid             = 1'b1;
        enq_group_counter     = 5'd5;
        enq_vd                = 5'd3;
        enq_mask              = 4'hF;
        enq_data              = 32'hA5A5_0001;
        enq_instruction_index = 3'd2;
        #1;
        nchecks++; if (enq_ready !== 1'b1) begin nerrors++; $display("FAIL normal_enq_ready: got %b expected 1", enq_ready); end
        nchecks++; if (vrf_valid !== 1'b0) begin nerrors++; $display("FAIL normal_no_bypass: got %b expected 0", vrf_valid); end
        tick();
        idle_inputs();
        #1;
        nchecks++; if (vrf_valid !== 1'b1) begin nerrors++; $display("FAIL normal_valid: got %b expected 1", vrf_valid); end
        nchecks++; if (vrf_vd !== 5'd5) begin nerrors++; $display("FAIL normal_vd: got %0d expected 5", vrf_vd); end
        nchecks++; if (vrf_offset !== 1'b1) begin nerrors++; $display("FAIL normal_offset: got %0d expected 1", vrf_offset); end
        nchecks++; if (vrf_mask !== 4'hF) begin nerrors++; $display("FAIL normal_mask: got %h expected f", vrf_mask); end
        nchecks++; if (vrf_data !== 32'hA5A5_0001) begin nerrors++; $display("FAIL normal_data: got %h expected a5a50001", vrf_data); end
        nchecks++; if (vrf_instruction_index !== 3'd2) begin nerrors++; $display("FAIL normal_tag: got %0d expected 2", vrf_instruction_index); end
        nchecks++; if (inst_pending !== 8'h04) begin nerrors++; $display("FAIL normal_pending: got %h expected 04", inst_pending); end
        nchecks++; if (queue_empty !== 1'b0) begin nerrors++; $display("FAIL normal_queue_empty: got %b expected 0", queue_empty); end
        tick();
        nchecks++; if (inst_pending !== 8'h04) begin nerrors++; $display("FAIL normal_pending_held: got %h expected 04", inst_pending); end
        vrf_ready = 1'b1;
        tick();
        vrf_ready = 1'b0;
        #1;
        nchecks++; if (vrf_valid !== 1'b0) begin nerrors++; $display("FAIL normal_popped: got %b expected 0", vrf_valid); end
        nchecks++; if (inst_pending !== 8'h00) begin nerrors++; $display("FAIL normal_retired: got %h expected 00", inst_pending); end
    endtask

    task automatic test_cross();
        vrf_ready             = 1'b1;
        enq_valid             = 1'b1;
        enq_cross_write       = 1'b1;
        enq_group_counter     = 5'd3;
        enq_vd                = 5'd1;
        enq_cross_mask        = 8'h3F;
        enq_cross_data        = {32'hBBBB_0002, 32'hAAAA_0001};
        enq_last              = 1'b1;
        enq_instruction_index = 3'd5;
        #1;
        nchecks++; if (enq_ready !== 1'b1) begin nerrors++; $display("FAIL cross_enq_ready: got %b expected 1", enq_ready); end
        tick();
        idle_inputs();
        #1;
        nchecks++; if (enq_ready !== 1'b0) begin nerrors++; $display("FAIL cross_split_ready: got %b expected 0", enq_ready); end
        nchecks++; if ({vrf_valid, vrf_vd, vrf_offset, vrf_mask, vrf_last} !== {1'b1, 5'd4, 1'b0, 4'hF, 1'b0})
            begin nerrors++; $display("FAIL cross_half0: got v%b vd%0d off%0d m%h l%b expected v1 vd4 off0 mf l0", vrf_valid, vrf_vd, vrf_offset, vrf_mask, vrf_last); end
        nchecks++; if (vrf_data !== 32'hAAAA_0001) begin nerrors++; $display("FAIL cross_half0_data: got %h expected aaaa0001", vrf_data); end
        nchecks++; if (inst_pending !== 8'h20) begin nerrors++; $display("FAIL cross_pending: got %h expected 20", inst_pending); end
        tick();
        nchecks++; if (enq_ready !== 1'b1) begin nerrors++; $display("FAIL cross_after_split_ready: got %b expected 1", enq_ready); end
        nchecks++; if ({vrf_valid, vrf_vd, vrf_offset, vrf_mask, vrf_last} !== {1'b1, 5'd4, 1'b1, 4'h3, 1'b1})
            begin nerrors++; $display("FAIL cross_half1: got v%b vd%0d off%0d m%h l%b expected v1 vd4 off1 m3 l1", vrf_valid, vrf_vd, vrf_offset, vrf_mask, vrf_last); end
        nchecks++; if (vrf_data !== 32'hBBBB_0002) begin nerrors++; $display("FAIL cross_half1_data: got %h expected bbbb0002", vrf_data); end
        nchecks++; if (inst_pending !== 8'h20) begin nerrors++; $display("FAIL cross_pending_half1: got %h expected 20", inst_pending); end
        tick();
        nchecks++; if (vrf_valid !== 1'b0) begin nerrors++; $display("FAIL cross_drained: got %b expected 0", vrf_valid); end
        nchecks++; if (inst_pending !== 8'h00) begin nerrors++; $display("FAIL cross_retired: got %h expected 00", inst_pending); end
    endtask

    task automatic test_zero_mask();
        vrf_ready             = 1'b1;
        enq_valid             = 1'b1;
        enq_mask              = 4'h0;
        enq_last              = 1'b0;
        enq_instruction_index = 3'd1;
        #1;
        nchecks++; if (enq_ready !== 1'b1) begin nerrors++; $display("FAIL zero_drop_ready: got %b expected 1", enq_ready); end
        tick();
        idle_inputs();
        #1;
        nchecks++; if (vrf_valid !== 1'b0) begin nerrors++; $display("FAIL zero_drop_valid: got %b expected 0", vrf_valid); end
        nchecks++; if (inst_pending !== 8'h00) begin nerrors++; $display("FAIL zero_drop_pending: got %h expected 00", inst_pending); end
        nchecks++; if (enq_ready !== 1'b1) begin nerrors++; $display("FAIL zero_drop_ready_after: got %b expected 1", enq_ready); end
        enq_valid             = 1'b1;
        enq_mask              = 4'h0;
        enq_last              = 1'b1;
        enq_vd                = 5'd7;
        enq_instruction_index = 3'd1;
        tick();
        idle_inputs();
        #1;
        nchecks++; if ({vrf_valid, vrf_vd, vrf_mask, vrf_last} !== {1'b1, 5'd7, 4'h0, 1'b1})
            begin nerrors++; $display("FAIL zero_last: got v%b vd%0d m%h l%b expected v1 vd7 m0 l1", vrf_valid, vrf_vd, vrf_mask, vrf_last); end
        nchecks++; if (inst_pending !== 8'h02) begin nerrors++; $display("FAIL zero_last_pending: got %h expected 02", inst_pending); end
        tick();
        nchecks++; if (vrf_valid !== 1'b0) begin nerrors++; $display("FAIL zero_last_popped: got %b expected 0", vrf_valid); end
    endtask

    task automatic test_backpressure();
        vrf_ready             = 1'b0;
        enq_mask              = 4'hF;
        enq_instruction_index = 3'd3;
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_data  = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        idle_inputs();
        #1;
        nchecks++; if (enq_ready !== 1'b0) begin nerrors++; $display("FAIL bp_full_ready: got %b expected 0", enq_ready); end
        nchecks++; if (vrf_data !== 32'hC0DE_0000) begin nerrors++; $display("FAIL bp_head: got %h expected c0de0000", vrf_data); end
        nchecks++; if (inst_pending !== 8'h08) begin nerrors++; $display("FAIL bp_pending: got %h expected 08", inst_pending); end
        tick();
        nchecks++; if ({vrf_valid, vrf_data} !== {1'b1, 32'hC0DE_0000}) begin nerrors++; $display("FAIL bp_stable: got v%b %h expected v1 c0de0000", vrf_valid, vrf_data); end
        vrf_ready             = 1'b1;
        enq_valid             = 1'b1;
        enq_mask              = 4'hF;
        enq_instruction_index = 3'd3;
        enq_data              = 32'hC0DE_0004;
        #1;
        nchecks++; if (enq_ready !== 1'b1) begin nerrors++; $display("FAIL bp_pop_frees_slot: got %b expected 1", enq_ready); end
        tick();
        vrf_ready = 1'b0;
        idle_inputs();
        #1;
        nchecks++; if (enq_ready !== 1'b0) begin nerrors++; $display("FAIL bp_still_full: got %b expected 0", enq_ready); end
        vrf_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            nchecks++; if ({vrf_valid, vrf_data} !== {1'b1, 32'hC0DE_0000 + 32'(i)})
                begin nerrors++; $display("FAIL bp_order_%0d: got v%b %h expected v1 %h", i, vrf_valid, vrf_data, 32'hC0DE_0000 + 32'(i)); end
            tick();
        end
        vrf_ready = 1'b0;
        #1;
        nchecks++; if ({vrf_valid, inst_pending} !== {1'b0, 8'h00}) begin nerrors++; $display("FAIL bp_drained: got v%b p%h expected v0 p00", vrf_valid, inst_pending); end
    endtask

    task automatic test_wrap();
        vrf_ready         = 1'b1;
        enq_valid         = 1'b1;
        enq_vd            = 5'd31;
        enq_group_counter = 5'd2;
        enq_mask          = 4'hF;
        enq_data          = 32'h0000_0FFF;
        tick();
        #1;
        nchecks++; if ({vrf_valid, vrf_vd, vrf_offset} !== {1'b1, 5'd0, 1'b0}) begin nerrors++; $display("FAIL wrap_vd: got v%b vd%0d off%0d expected v1 vd0 off0", vrf_valid, vrf_vd, vrf_offset); end
        for (int i = 0; i < 10; i++) begin
            enq_data          = 32'h0000_0100 + 32'(i);
            enq_group_counter = 5'(i);
            enq_vd            = 5'd0;
            tick();
            nchecks++; if ({vrf_valid, vrf_data} !== {1'b1, 32'h0000_0100 + 32'(i)})
                begin nerrors++; $display("FAIL wrap_order_%0d: got v%b %h expected v1 %h", i, vrf_valid, vrf_data, 32'h0000_0100 + 32'(i)); end
            nchecks++; if (vrf_vd !== 5'(i >> 1)) begin nerrors++; $display("FAIL wrap_addr_%0d: got %0d expected %0d", i, vrf_vd, i >> 1); end
        end
        idle_inputs();
        tick();
        nchecks++; if ({vrf_valid, queue_empty} !== {1'b0, 1'b1}) begin nerrors++; $display("FAIL wrap_drained: got v%b e%b expected v0 e1", vrf_valid, queue_empty); end
    endtask

    task automatic test_reset_split();
        vrf_ready             = 1'b0;
        enq_valid             = 1'b1;
        enq_cross_write       = 1'b1;
        enq_cross_mask        = 8'hFF;
        enq_cross_data        = {32'hDEAD_0002, 32'hDEAD_0001};
        enq_last              = 1'b1;
        enq_instruction_index = 3'd6;
        tick();
        idle_inputs();
        #1;
        nchecks++; if (enq_ready !== 1'b0) begin nerrors++; $display("FAIL rst_split_in_split: got %b expected 0", enq_ready); end
        reset = 1'b0;
        #1;
        nchecks++; if ({vrf_valid, inst_pending} !== {1'b0, 8'h00}) begin nerrors++; $display("FAIL rst_split_async: got v%b p%h expected v0 p00", vrf_valid, inst_pending); end
        tick();
        reset = 1'b1;
        #1;
        nchecks++; if ({enq_ready, vrf_valid, inst_pending, queue_empty} !== {1'b1, 1'b0, 8'h00, 1'b1})
            begin nerrors++; $display("FAIL rst_split_release: got r%b v%b p%h e%b expected r1 v0 p00 e1", enq_ready, vrf_valid, inst_pending, queue_empty); end
        vrf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nchecks++; if (vrf_valid !== 1'b0) begin nerrors++; $display("FAIL rst_split_stale_%0d: got %b expected 0", i, vrf_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_cross();
        test_zero_mask();
        test_backpressure();
        test_wrap();
        test_reset_split();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
